gf2m_binary_divider: RTL
========================

Name: gf2m_binary_divider

Overview:
- Sequential GF(2^163) divider: computes Z = A · B^-1 mod f(x), with f(x) = x^163 + x^7 + x^6 + x^3 + 1.
- Uses the binary extended Euclidean algorithm (Shantz), one reduction step per clock.
- It is the inverse-direction companion to the interleaved multiplier in the ECC (B-163) datapath.
- Inversion is the special case A = 1.

Parameters:
- M, 163, field degree / operand width.
- POLY_LOW, 163'hC9, f(x) minus the x^M term (bits 7, 6, 3, 0).
- CNT_W, 11, width of the internal iteration counter; must hold 4*M.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE; operands are captured on the same edge.
- A  input  M  dividend, already reduced (< 2^M).
- B  input  M  divisor, already reduced.
- Z  output  M  quotient. Valid when done=1; held until the next accepted start.
- busy  output  1  high from the cycle after acceptance until done asserts.
- done  output  1  one-cycle pulse when Z and err are valid.
- err  output  1  set with done when B == 0 (Z = 0); held with Z.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE.
  - Z, busy, done, err = 0.
  - Internal registers u, v, x1, x2 and cnt = 0.
- Internal registers: u, v are M+1 bits; x1, x2 are M bits; cnt is CNT_W bits.
- States: IDLE, LOAD, ITER, FIN.
- IDLE:
  - On start=1: capture u={1'b0,B}, v={1'b1,POLY_LOW} (i.e. f), x1=A, x2=0, cnt=0; go to LOAD.
  - start=0 remains IDLE.
- LOAD (1 cycle), busy=1:
  - If u==0: Z=0, err=1; go to FIN.
  - Otherwise: err=0; go to ITER.
- ITER, busy=1. Exactly one action per cycle, evaluated in priority order:
  1. u==1: Z=x1; go to FIN.
  2. v==1: Z=x2; go to FIN.
  3. u[0]==0: u=u>>1; x1 = x1[0] ? (x1 ^ f)>>1 : x1>>1. The XOR with f sets the implicit bit M, so after the shift it lands at bit M-1.
  4. v[0]==0: same operation on v, x2.
  5. Otherwise, if u > v as unsigned M+1-bit integers: u=u^v, x1=x1^x2.
  6. Else: v=v^u, x2=x2^x1.
  - cnt increments on every ITER cycle.
- FIN: done=1 for exactly this cycle, busy=0; go to IDLE.
- Latency:
  - Start edge to done pulse is 3 + k cycles, where k is the number of ITER steps.
  - k ≤ 4*M = 652 for any nonzero B.
  - B==0 gives fixed latency 3 (IDLE → LOAD → FIN).
- Iteration guard: if cnt reaches 4*M without termination, force Z=0, err=1, go to FIN. This is unreachable for valid inputs; it is checked by assertion.
- Operand capture: A and B are sampled only at acceptance. Later changes on A/B have no effect.
- start while busy, or in FIN: ignored, not queued.
- start held high continuously: a new operation is accepted on the first IDLE cycle after done, i.e. back-to-back with one IDLE gap.
- Z and err update only on FIN entry. They hold across IDLE until the next LOAD/ITER completion.
- Reset mid-operation: immediate abort to reset values. No done pulse is emitted.
- All arithmetic is carry-free (XOR), except the u > v magnitude compare.

Test Plan:
- A=1, B=1 → done after 4 cycles (k=1), Z=1, err=0.
- A=1, B=163'h2 (x) → Z = 163'h4_0000_0000_0000_0000_0000_0000_0000_0000_0000_0064, i.e. x^162+x^6+x^5+x^2. This satisfies x·Z mod f = 1.
- A=163'h20, B=163'h2 → Z=163'h10; A=0, B=any nonzero → Z=0, err=0.
- B=0, A=163'h5 → done exactly 3 cycles after start, Z=0, err=1. A following valid op (A=1, B=1) clears err.
- 1000 random nonzero pairs:
  - Z·B mod f == A, using a reference model or the interleaved multiplier.
  - Latency ≤ 655 cycles; done high exactly one cycle; busy high on every cycle between acceptance and done.
- Robustness:
  - Pulse start again mid-ITER with different A/B → ignored; result matches the first operands.
  - Assert rst_n low mid-ITER → Z=0, busy=0, done=0 asynchronously; no done pulse. Next start completes correctly.

Source files
------------

// File: rtl/gf2m_binary_divider.sv
// GF(2^M) divider Z = A / B mod f(x) using the binary extended Euclidean
// algorithm: one halving or XOR-reduction step per clock.
// Invariants while iterating: x1*B == A*u and x2*B == A*v (mod f).
// Reaching u==1 or v==1 therefore leaves the quotient in x1 or x2.
module gf2m_binary_divider #(
    parameter int              M        = 163,
    parameter logic [M-1:0]    POLY_LOW = 163'hC9,
    parameter int              CNT_W    = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic [M-1:0] Z,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, LOAD, ITER, FIN} state_t;

    localparam logic [M:0]       ONE   = (M+1)'(1);
    localparam logic [CNT_W-1:0] GUARD = CNT_W'(4*M);

    state_t           state, state_n;
    logic [M:0]       u, v, u_n, v_n;
    logic [M-1:0]     x1, x2, x1_n, x2_n, z_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             err_n;

    // x / x mod f: odd values take f first, which sets the implicit bit M
    // that then shifts down into bit M-1.
    function automatic logic [M-1:0] half_mod(input logic [M-1:0] x);
        if (x[0])
            half_mod = {1'b1, x[M-1:1] ^ POLY_LOW[M-1:1]};
        else
            half_mod = {1'b0, x[M-1:1]};
    endfunction

    // State register and all datapath registers; outputs are registered
    // from the next state so done is high exactly in the FIN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            u     <= '0;
            v     <= '0;
            x1    <= '0;
            x2    <= '0;
            cnt   <= '0;
            Z     <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            u     <= u_n;
            v     <= v_n;
            x1    <= x1_n;
            x2    <= x2_n;
            cnt   <= cnt_n;
            Z     <= z_n;
            err   <= err_n;
            busy  <= (state_n == LOAD) || (state_n == ITER);
            done  <= (state_n == FIN);
        end
    end

    // Next-state and single reduction step selection, in priority order.
    always_comb begin
        state_n = state;
        u_n     = u;
        v_n     = v;
        x1_n    = x1;
        x2_n    = x2;
        cnt_n   = cnt;
        z_n     = Z;
        err_n   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    u_n     = {1'b0, B};
                    v_n     = {1'b1, POLY_LOW};
                    x1_n    = A;
                    x2_n    = '0;
                    cnt_n   = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (u == '0) begin
                    z_n     = '0;
                    err_n   = 1'b1;
                    state_n = FIN;
                end else begin
                    err_n   = 1'b0;
                    state_n = ITER;
                end
            end
            ITER: begin
                cnt_n = cnt + 1'b1;
                if (u == ONE) begin
                    z_n     = x1;
                    state_n = FIN;
                end else if (v == ONE) begin
                    z_n     = x2;
                    state_n = FIN;
                end else if (cnt == GUARD) begin
                    // non-terminating run: cannot happen with a valid f
                    z_n     = '0;
                    err_n   = 1'b1;
                    state_n = FIN;
                end else if (!u[0]) begin
                    u_n  = u >> 1;
                    x1_n = half_mod(x1);
                end else if (!v[0]) begin
                    v_n  = v >> 1;
                    x2_n = half_mod(x2);
                end else if (u > v) begin
                    u_n  = u ^ v;
                    x1_n = x1 ^ x2;
                end else begin
                    v_n  = v ^ u;
                    x2_n = x2 ^ x1;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The iteration guard must never fire for a reduced, nonzero divisor.
    a_guard_unreachable: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == ITER && cnt == GUARD && u != ONE && v != ONE));

endmodule
